// File: rtl/uart_rx_oversampled.sv
// UART receiver: 16x oversampled line with 3-sample majority vote per bit,
// parity/stop/break checking, and a first-word-fall-through FIFO of
// {frame_err, parity_err, data} entries drained by a valid/ready handshake.
module uart_rx_oversampled #(
  parameter int unsigned CLOCK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_EN   = 1,
  parameter int unsigned PARITY_TYPE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  output logic                          break_det,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PW      = $clog2(OVERSAMPLE);
  localparam int unsigned M       = OVERSAMPLE / 2;
  localparam int unsigned BW      = $clog2(DATA_BITS + 1);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned EW      = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]        tick_cnt;
  logic                 tick;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [PW-1:0]        phase;
  logic                 s_a, s_b;
  logic                 vote;
  logic                 decide;
  logic                 bit_end;
  logic [DATA_BITS-1:0] shift;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_idx;
  logic                 last_stop;
  logic                 parity_err;
  logic                 frame_err;
  logic                 par_bit;
  logic                 par_exp;
  logic                 is_break;
  logic                 push_req;
  logic                 brk_req;
  logic                 push_q;
  logic [EW-1:0]        entry_q;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW:0]          wptr, rptr;
  logic                 empty, full, pop, wr_ok;
  logic [EW-1:0]        head;

  assign tick = (tick_cnt == CW'(DIV - 1));

  // Free-running sample-tick divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Two-flop synchronizer for the asynchronous line, idle-high after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end

  assign rx_s = sync[1];

  // Bit phase counter; held at 0 while idle so the detecting tick is phase 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (tick) begin
      if (state == S_IDLE || phase == PW'(OVERSAMPLE - 1)) phase <= '0;
      else                                                 phase <= phase + 1'b1;
    end
  end

  // Capture the two early mid-bit samples; the third is live at the decision phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else if (tick) begin
      if (phase == PW'(M - 1)) s_a <= rx_s;
      if (phase == PW'(M))     s_b <= rx_s;
    end
  end

  assign vote      = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
  assign decide    = tick && (phase == PW'(M + 1));
  assign bit_end   = tick && (phase == PW'(OVERSAMPLE - 1));
  assign last_stop = (STOP_BITS == 1) || stop_idx;
  assign par_exp   = (PARITY_TYPE != 0) ? ~^shift : ^shift;
  assign is_break  = (shift == '0) && ((PARITY_EN == 0) || !par_bit) && !vote;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (tick && !rx_s) state_next = S_START;
      S_START: begin
        if (decide && vote) state_next = S_IDLE;
        else if (bit_end)   state_next = S_DATA;
      end
      S_DATA:   if (bit_end && bit_cnt == BW'(DATA_BITS))
                  state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_next = S_STOP;
      S_STOP:   if (decide && last_stop) state_next = is_break ? S_BRK : S_IDLE;
      S_BRK:    if (tick && rx_s) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // FSM outputs: push or break request at the final stop-bit decision
  always_comb begin
    push_req = 1'b0;
    brk_req  = 1'b0;
    if (state == S_STOP && decide && last_stop) begin
      if (is_break) brk_req  = 1'b1;
      else          push_req = 1'b1;
    end
  end

  // Frame datapath: shift register, bit/stop counters and error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift      <= '0;
      bit_cnt    <= '0;
      stop_idx   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      par_bit    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick && !rx_s) begin
            bit_cnt    <= '0;
            stop_idx   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            par_bit    <= 1'b0;
          end
        end
        S_DATA: begin
          if (decide) begin
            shift   <= {vote, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (decide) begin
            par_bit    <= vote;
            parity_err <= (vote != par_exp);
          end
        end
        S_STOP: begin
          if (decide && !vote)          frame_err <= 1'b1;
          if (bit_end && !last_stop)    stop_idx  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Register the completed entry and the break pulse; the FIFO write lands one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_q    <= 1'b0;
      entry_q   <= '0;
      break_det <= 1'b0;
    end else begin
      push_q    <= push_req;
      break_det <= brk_req;
      if (push_req) entry_q <= {frame_err | ~vote, parity_err, shift};
    end
  end

  assign empty      = (wptr == rptr);
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rx_valid   = !empty;
  assign pop        = rx_valid && rx_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push then
  assign wr_ok      = push_q && (!full || pop);
  assign fifo_count = wptr - rptr;

  // FIFO pointers and overrun pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      overrun <= push_q && full && !pop;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= entry_q;
  end

  // First-word-fall-through head, forced to zero while empty
  always_comb begin
    head          = mem[rptr[AW-1:0]];
    rx_data       = '0;
    rx_parity_err = 1'b0;
    rx_frame_err  = 1'b0;
    if (rx_valid) begin
      rx_data[DATA_BITS-1:0] = head[DATA_BITS-1:0];
      rx_parity_err          = head[DATA_BITS];
      rx_frame_err           = head[DATA_BITS+1];
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: 8E1 frames at 4 clocks per sample tick.
module tb_uart_rx_oversampled;

  localparam int BIT_CLKS = 64;  // 16 samples x 4 clocks per tick

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic       break_det;
  logic [3:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ovr    = 0;
  int n_brk    = 0;
  logic [9:0] got_q[$];

  uart_rx_oversampled #(
    .CLOCK_FREQ (7_372_800),
    .BAUD_RATE  (115200),
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .PARITY_EN  (1),
    .PARITY_TYPE(0),
    .STOP_BITS  (1),
    .FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .overrun      (overrun),
    .break_det    (break_det),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted beats and count pulses, sampled on the falling edge
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back({rx_frame_err, rx_parity_err, rx_data});
    if (overrun)   n_ovr++;
    if (break_det) n_brk++;
  end

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_zero);
    rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(posedge clk);
    end
    rx = (^d) ^ bad_par;
    repeat (BIT_CLKS) @(posedge clk);
    rx = ~stop_zero;
    repeat (BIT_CLKS) @(posedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    n_checks++; if ({rx_frame_err, rx_parity_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {rx_frame_err, rx_parity_err}); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    n_checks++; if (break_det !== 1'b0) begin n_fail++; $display("FAIL reset_break got=%b exp=0", break_det); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [9:0] e;
    got_q.delete();
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL basic_beats got=%0d exp=1", got_q.size()); end
    e = (got_q.size() > 0) ? got_q[0] : 10'h3ff;
    n_checks++; if (e !== {2'b00, 8'h55}) begin n_fail++; $display("FAIL basic_entry got=%h exp=%h", e, {2'b00, 8'h55}); end
    n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL basic_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_parity_err();
    logic [9:0] e;
    got_q.delete();
    send_frame(8'hA3, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL parity_beats got=%0d exp=1", got_q.size()); end
    e = (got_q.size() > 0) ? got_q[0] : 10'h3ff;
    n_checks++; if (e !== {2'b01, 8'hA3}) begin n_fail++; $display("FAIL parity_entry got=%h exp=%h", e, {2'b01, 8'hA3}); end
  endtask

  task automatic test_frame_err();
    logic [9:0] e;
    int brk0;
    brk0 = n_brk;
    got_q.delete();
    send_frame(8'h3C, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL frame_beats got=%0d exp=1", got_q.size()); end
    e = (got_q.size() > 0) ? got_q[0] : 10'h3ff;
    n_checks++; if (e !== {2'b10, 8'h3C}) begin n_fail++; $display("FAIL frame_entry got=%h exp=%h", e, {2'b10, 8'h3C}); end
    n_checks++; if (n_brk - brk0 !== 0) begin n_fail++; $display("FAIL frame_no_break got=%0d exp=0", n_brk - brk0); end
  endtask

  task automatic test_glitch();
    logic [9:0] e;
    got_q.delete();
    rx = 1'b0;
    repeat (12) @(posedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    @(negedge clk);
    n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL glitch_count got=%0d exp=0", fifo_count); end
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL glitch_beats got=%0d exp=0", got_q.size()); end
    send_frame(8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    e = (got_q.size() > 0) ? got_q[0] : 10'h3ff;
    n_checks++; if (e !== {2'b00, 8'h5A}) begin n_fail++; $display("FAIL glitch_next_entry got=%h exp=%h", e, {2'b00, 8'h5A}); end
  endtask

  task automatic test_overrun();
    logic [9:0] e;
    int ovr0;
    got_q.delete();
    rx_ready = 1'b0;
    ovr0 = n_ovr;
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (n_ovr - ovr0 !== 0) begin n_fail++; $display("FAIL ovr_before_ninth got=%0d exp=0", n_ovr - ovr0); end
    send_frame(8'h09, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL ovr_count got=%0d exp=8", fifo_count); end
    n_checks++; if (n_ovr - ovr0 !== 1) begin n_fail++; $display("FAIL ovr_pulses got=%0d exp=1", n_ovr - ovr0); end
    rx_ready = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL ovr_drain_beats got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      e = (got_q.size() > i) ? got_q[i] : 10'h3ff;
      n_checks++; if (e !== {2'b00, 8'(i + 1)}) begin n_fail++; $display("FAIL ovr_drain_%0d got=%h exp=%h", i, e, {2'b00, 8'(i + 1)}); end
    end
    n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL ovr_drained_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_break();
    int brk0;
    brk0 = n_brk;
    got_q.delete();
    rx = 1'b0;
    repeat (22 * BIT_CLKS) @(posedge clk);
    rx = 1'b1;
    repeat (4 * BIT_CLKS) @(posedge clk);
    @(negedge clk);
    n_checks++; if (n_brk - brk0 !== 1) begin n_fail++; $display("FAIL break_pulses got=%0d exp=1", n_brk - brk0); end
    n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL break_count got=%0d exp=0", fifo_count); end
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL break_beats got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_mid_reset();
    logic [9:0] e;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL midrst_pre_count got=%0d exp=1", fifo_count); end
    rx = 1'b0;
    repeat (3 * BIT_CLKS) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", rx_valid); end
    n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", fifo_count); end
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    got_q.delete();
    rx_ready = 1'b1;
    send_frame(8'h7E, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL midrst_beats got=%0d exp=1", got_q.size()); end
    e = (got_q.size() > 0) ? got_q[0] : 10'h3ff;
    n_checks++; if (e !== {2'b00, 8'h7E}) begin n_fail++; $display("FAIL midrst_entry got=%h exp=%h", e, {2'b00, 8'h7E}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_break();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
